// File: rtl/ws2812_frame_ctrl_if.sv
// Requester write bus for ws2812_frame_ctrl.
// Carries two independent valid/ready pixel-write channels:
//   A (host) and B (effect engine), each with index, 24-bit {G,R,B} value, valid and ready.
// master: driven by the requesters; slave: driven by the frame controller (readies only).
interface ws2812_frame_ctrl_if #(
  parameter int unsigned IDX_W = 2
);
  logic             a_valid;
  logic             a_ready;
  logic [IDX_W-1:0] a_index;
  logic [23:0]      a_rgb;
  logic             b_valid;
  logic             b_ready;
  logic [IDX_W-1:0] b_index;
  logic [23:0]      b_rgb;

  modport master (
    output a_valid, a_index, a_rgb, b_valid, b_index, b_rgb,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_index, a_rgb, b_valid, b_index, b_rgb,
    output a_ready, b_ready
  );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// Frame controller in front of the ws2812 serial driver.
// Two requesters write pixels into a shadow buffer (round-robin on contention); the shadow is
// copied to the driver bus in one shot, only in the cycle after a driver latch-gap pulse, so a
// frame never mixes old and new pixels.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req (slave)         requester A/B write channels (valid/ready/index/rgb)
//   commit              one-cycle request to publish at the next drv_gap
//   drv_gap             one-cycle pulse from the driver at the start of the latch gap
//   packed_rgb_data     active pixel data, pixel i at [24*i +: 24]
//   commit_pending      publish armed, waiting for drv_gap
//   frame_count         completed publishes (wrapping)
//   idx_err             sticky: an out-of-range write was accepted
// Optional feature: define WS2812_FRAME_CTRL_AUTOCOMMIT_EN to publish automatically at a gap
// whenever the shadow holds unpublished writes.
module ws2812_frame_ctrl #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  ws2812_frame_ctrl_if.slave      req,
  input  logic                    commit,
  input  logic                    drv_gap,
  output logic [NUM_LEDS*24-1:0]  packed_rgb_data,
  output logic                    commit_pending,
  output logic [15:0]             frame_count,
  output logic                    idx_err
);

  typedef enum logic [1:0] {StIdle, StPending, StCopy} state_e;

  state_e                  state_q, state_d;
  logic                    last_b_q;  // 1: B was granted last, so A wins the next tie
  logic [NUM_LEDS*24-1:0]  shadow_q, shadow_d;
  logic [NUM_LEDS*24-1:0]  packed_q;
  logic [15:0]             frame_count_q;
  logic                    idx_err_q;

  logic                    a_grant, b_grant, wr_en, in_range;
  logic [IDX_W-1:0]        wr_idx;
  logic [23:0]             wr_rgb;

`ifdef WS2812_FRAME_CTRL_AUTOCOMMIT_EN
  logic                    dirty_q;
`endif

  // Grants: no writes during the copy cycle so the snapshot is coherent.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (state_q != StCopy) begin
      if (req.a_valid && req.b_valid) begin
        a_grant = last_b_q;
        b_grant = !last_b_q;
      end else begin
        a_grant = req.a_valid;
        b_grant = req.b_valid;
      end
    end
  end

  assign req.a_ready = a_grant;
  assign req.b_ready = b_grant;

  assign wr_en  = a_grant || b_grant;
  assign wr_idx = a_grant ? req.a_index : req.b_index;
  assign wr_rgb = a_grant ? req.a_rgb : req.b_rgb;

  // Decode the index against real pixels only; unmatched indices are dropped.
  always_comb begin
    shadow_d = shadow_q;
    in_range = 1'b0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        in_range = 1'b1;
        if (wr_en) shadow_d[24*i +: 24] = wr_rgb;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          state_d = StPending;
`ifdef WS2812_FRAME_CTRL_AUTOCOMMIT_EN
        end else if (drv_gap && dirty_q) begin
          state_d = StCopy;
`endif
        end
      end
      StPending: if (drv_gap) state_d = StCopy;
      StCopy:    state_d = commit ? StPending : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      last_b_q      <= 1'b1;
      shadow_q      <= '0;
      packed_q      <= '0;
      frame_count_q <= '0;
      idx_err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      if (wr_en) last_b_q <= b_grant;
      if (wr_en && !in_range) idx_err_q <= 1'b1;
      if (state_q == StCopy) begin
        packed_q      <= shadow_q;
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

`ifdef WS2812_FRAME_CTRL_AUTOCOMMIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty_q <= 1'b0;
    end else if (state_q == StCopy) begin
      dirty_q <= 1'b0;
    end else if (wr_en && in_range) begin
      dirty_q <= 1'b1;
    end
  end
`endif

  assign packed_rgb_data = packed_q;
  assign commit_pending  = (state_q == StPending);
  assign frame_count     = frame_count_q;
  assign idx_err         = idx_err_q;

endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
- Frame controller sitting in front of the ws2812 serial driver.
- Arbitrates pixel writes from two requesters (A: host, B: effect engine) into a shadow pixel buffer.
- Publishes the shadow buffer to the driver's packed_rgb_data bus atomically, only during the driver's inter-frame latch gap, so a frame never mixes old and new pixels.

Parameters:
NUM_LEDS, 4, number of pixels; packed_rgb_data width = NUM_LEDS*24
IDX_W, 2, pixel index width; must satisfy 2**IDX_W >= NUM_LEDS

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
a_valid  input  1  requester A write request
a_ready  output  1  requester A grant; write occurs on a_valid&&a_ready
a_index  input  IDX_W  requester A pixel index
a_rgb  input  24  requester A pixel value {G,R,B}, driver bit order
b_valid  input  1  requester B write request
b_ready  output  1  requester B grant
b_index  input  IDX_W  requester B pixel index
b_rgb  input  24  requester B pixel value
commit  input  1  one-cycle request to publish shadow at next gap
drv_gap  input  1  one-cycle pulse from driver at start of latch/reset gap
packed_rgb_data  output  NUM_LEDS*24  active pixel data to driver; pixel i at [24*i +: 24]
commit_pending  output  1  commit armed, waiting for drv_gap
frame_count  output  16  number of completed publishes, wraps 0xFFFF->0
idx_err  output  1  sticky: a write with index >= NUM_LEDS was accepted

Behaviour:
- Reset (reset==0, async): shadow=0, packed_rgb_data=0, state=IDLE, commit_pending=0, frame_count=0, idx_err=0, rr pointer=B (A wins first tie).
- Ready is combinational from valid, rr pointer and state; x_ready never asserts without x_valid; at most one ready high per cycle.
- Arbitration: only one valid -> that requester granted. Both valid -> round robin; grant goes to requester not granted last; pointer updates only on an accepted write.
- Accepted write updates shadow[24*index +: 24] at that edge; visible on packed_rgb_data only after the next publish.
- Index >= NUM_LEDS: write accepted (handshake completes), data discarded, idx_err set until reset.
- State machine:
  - IDLE: commit -> PENDING.
  - PENDING: drv_gap -> COPY; commit ignored (absorbed).
  - COPY (exactly 1 cycle): a_ready=b_ready=0; on the leaving edge packed_rgb_data<=shadow, frame_count+=1; next state IDLE, or PENDING if commit is high during COPY.
- commit_pending = (state==PENDING).
- Writes accepted in the commit cycle or during PENDING are included in the publish.
- Simultaneous commit and drv_gap in IDLE: go to PENDING only; wait for the next drv_gap.
- drv_gap in IDLE: ignored.
- Reset mid-PENDING/COPY: all state cleared, no publish.
- packed_rgb_data changes only on the COPY exit edge, never elsewhere.

Optional Feature:
- Macro: WS2812_FRAME_CTRL_AUTOCOMMIT_EN.
- Enabled:
  - Internal dirty flag set by any accepted in-range write; cleared on COPY exit.
  - drv_gap in IDLE with dirty=1 -> COPY directly, no commit needed.
  - Explicit commit still works as above.
- Disabled: no dirty flag; publish only via commit.

Test Plan:
- Reset release, A writes idx0=0xFFFFFF, no commit, 3 drv_gap pulses -> packed_rgb_data stays 0, frame_count=0.
- A writes idx1=0x00FF00, commit, drv_gap 5 cycles later -> commit_pending high 5 cycles; packed_rgb_data[47:24]=0x00FF00 one cycle after the COPY cycle; frame_count=1.
- A and B both valid for 4 cycles -> grants A,B,A,B; never both ready in one cycle.
- Writes held valid across drv_gap while pending -> both readies low exactly one cycle (COPY), then resume; no write lost.
- B writes idx 3 (NUM_LEDS=3 build) -> b_ready handshake completes, idx_err=1, packed data unchanged after commit+gap.
- AUTOCOMMIT_EN build: single A write idx2=0x0000FF, then drv_gap -> published without commit, frame_count=1; a second drv_gap with no writes -> frame_count stays 1.
